multichannel_delay_line: RTL and testbench

Parametrised, multi-channel, fixed-latency sample delay line with a run-time programmable delay, input-valid gating and fill tracking. All channels share one pointer set and shift together, so channel alignment is preserved. It sits in the sample datapath wherever parallel streams must be time-aligned against a slower path, for example an I/Q pair. It replaces hard-wired tap shift registers with a RAM-based circular buffer.

---
 rtl/delay_line_pkg.sv | 30 +++
 rtl/multichannel_delay_line_ram.sv | 39 +++
 rtl/multichannel_delay_line.sv | 89 ++++++++
 tb/tb_multichannel_delay_line.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/delay_line_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// delay_line_pkg: width helpers, delay clamp and defaults for the delay line
// Revision 1.0
// ---------------------------------------------------------------------------
package delay_line_pkg;

  localparam int MAX_DEPTH_DEF     = 1024;
  localparam int DEFAULT_DELAY_DEF = 64;

  function automatic int ptr_w(input int max_depth);
    return $clog2(max_depth);
  endfunction

  function automatic int dly_w(input int max_depth);
    return $clog2(max_depth) + 1;
  endfunction

  // A zero delay has no meaning for a circular buffer, so it becomes one sample.
  function automatic int clamp_delay(input int req, input int max_depth);
    if (req < 1)
      return 1;
    else if (req > max_depth)
      return max_depth;
    else
      return req;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multichannel_delay_line_ram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// delay_ram: simple dual-port RAM, synchronous write, read-before-write
// Revision 1.0
// ---------------------------------------------------------------------------
module delay_ram
  import delay_line_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  localparam int AW    = ptr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_addr] <= wr_data;
  end

  // Non-blocking update returns the old word when rd_addr == wr_addr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rd_data <= '0;
    else if (rd_en)
      rd_data <= mem[rd_addr];
  end

endmodule
`default_nettype wire

// File: rtl/multichannel_delay_line.sv
`default_nettype none
// ---------------------------------------------------------------------------
// multichannel_delay_line: RAM-based programmable delay, channels shift together
// Revision 1.0
// ---------------------------------------------------------------------------
module multichannel_delay_line
  import delay_line_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int CHANNELS      = 2,
  parameter int MAX_DEPTH     = MAX_DEPTH_DEF,
  parameter int DEFAULT_DELAY = DEFAULT_DELAY_DEF,
  localparam int PW           = ptr_w(MAX_DEPTH),
  localparam int DW           = dly_w(MAX_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic                      cfg_load,
  input  logic [DW-1:0]             cfg_delay,
  output logic                      out_valid,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic                      filled,
  output logic [DW-1:0]             cur_delay
);

  localparam logic [DW-1:0] MAX_FILL  = DW'(MAX_DEPTH);
  localparam logic [DW-1:0] RST_DELAY = DW'(DEFAULT_DELAY);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_addr;
  logic [DW-1:0] fill;
  logic [DW-1:0] delay;
  logic [DW-1:0] load_delay;
  logic [DW-1:0] delay_next;
  logic [DW-1:0] fill_next;
  logic          fill_ok;
  logic          emit;

  assign load_delay = DW'(clamp_delay(int'(cfg_delay), MAX_DEPTH));
  assign delay_next = cfg_load ? load_delay : delay;

  // A load restarts the fill; a simultaneous accept is the first new sample.
  assign fill_next  = cfg_load          ? {{(DW-1){1'b0}}, in_valid} :
                      (fill == MAX_FILL) ? fill : fill + DW'(1);

  assign fill_ok    = (fill >= delay);
  assign emit       = in_valid & fill_ok & ~cfg_load;
  // D = MAX_DEPTH has zero low bits, so the read lands on the write address.
  assign rd_addr    = wr_ptr - delay[PW-1:0];
  assign cur_delay  = delay;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      fill      <= '0;
      delay     <= RST_DELAY;
      out_valid <= 1'b0;
      filled    <= 1'b0;
    end else begin
      out_valid <= emit;
      if (in_valid)
        wr_ptr <= wr_ptr + PW'(1);
      if (in_valid || cfg_load) begin
        delay  <= delay_next;
        fill   <= fill_next;
        filled <= (fill_next >= delay_next);
      end
    end
  end

  // Reads are gated by emit so out_data holds its value between valid outputs.
  delay_ram #(
    .DATA_W (CHANNELS*WIDTH),
    .DEPTH  (MAX_DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (in_valid),
    .wr_addr (wr_ptr),
    .wr_data (in_data),
    .rd_en   (emit),
    .rd_addr (rd_addr),
    .rd_data (out_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_multichannel_delay_line.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_multichannel_delay_line: scoreboard bench for the multichannel delay line
// Revision 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_multichannel_delay_line;

  localparam int MAXD = 1024;
  localparam int DEFD = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        cfg_load = 1'b0;
  logic [10:0] cfg_delay = '0;
  logic        out_valid;
  logic [31:0] out_data;
  logic        filled;
  logic [10:0] cur_delay;

  int checks = 0;
  int failures = 0;

  int          m_delay;
  int          m_fill;
  int          k;
  int          step_no;
  bit          exp_valid;
  logic [31:0] last_data;
  logic [31:0] epoch[$];
  logic [31:0] exp_q[$];

  multichannel_delay_line #(
    .WIDTH         (16),
    .CHANNELS      (2),
    .MAX_DEPTH     (MAXD),
    .DEFAULT_DELAY (DEFD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .cfg_load  (cfg_load),
    .cfg_delay (cfg_delay),
    .out_valid (out_valid),
    .out_data  (out_data),
    .filled    (filled),
    .cur_delay (cur_delay)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_delay   = DEFD;
    m_fill    = 0;
    last_data = '0;
    epoch.delete();
    exp_q.delete();
  endtask

  // One clock: drive, update reference model, then compare after the edge.
  task automatic step(input bit v, input bit ld, input int cfg);
    logic [31:0] d;
    logic [31:0] exp_d;
    d = {16'(k + 1000), 16'(k)};
    in_valid  = v;
    in_data   = d;
    cfg_load  = ld;
    cfg_delay = 11'(cfg);
    if (ld) begin
      exp_valid = 1'b0;
      m_delay   = (cfg == 0) ? 1 : ((cfg > MAXD) ? MAXD : cfg);
      m_fill    = 0;
      epoch.delete();
      if (v) begin
        epoch.push_back(d);
        m_fill = 1;
      end
    end else if (v) begin
      exp_valid = (m_fill >= m_delay);
      if (exp_valid)
        exp_q.push_back(epoch[epoch.size() - m_delay]);
      epoch.push_back(d);
      if (m_fill < MAXD)
        m_fill++;
    end else begin
      exp_valid = 1'b0;
    end
    if (v)
      k++;
    step_no++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cfg_load = 1'b0;

    checks++;
    if (out_valid !== exp_valid) begin
      failures++;
      $display("FAIL out_valid step %0d: got %b expected %b", step_no, out_valid, exp_valid);
    end
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_empty step %0d: got output %h expected none", step_no, out_data);
      end else begin
        exp_d = exp_q.pop_front();
        last_data = exp_d;
      end
    end
    checks++;
    if (out_data !== last_data) begin
      failures++;
      $display("FAIL out_data step %0d: got %h expected %h", step_no, out_data, last_data);
    end
    checks++;
    if (filled !== (m_fill >= m_delay)) begin
      failures++;
      $display("FAIL filled step %0d: got %b expected %b", step_no, filled, (m_fill >= m_delay));
    end
    checks++;
    if (cur_delay !== 11'(m_delay)) begin
      failures++;
      $display("FAIL cur_delay step %0d: got %0d expected %0d", step_no, cur_delay, m_delay);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || filled !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%b d=%h f=%b expected 0 0 0", out_valid, out_data, filled);
    end
    checks++;
    if (cur_delay !== 11'(DEFD)) begin
      failures++;
      $display("FAIL reset_delay: got %0d expected %0d", cur_delay, DEFD);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_stream();
    int first = -1;
    k = 0;
    step_no = 0;
    for (int i = 1; i <= 100; i++) begin
      step(1'b1, 1'b0, 0);
      if (out_valid === 1'b1 && first < 0)
        first = i;
    end
    checks++;
    if (first != 65) begin
      failures++;
      $display("FAIL first_output_cycle: got %0d expected 65", first);
    end
  endtask

  task automatic test_max_delay();
    step(1'b1, 1'b1, 1024);
    for (int i = 0; i < 1023 + 40; i++)
      step(1'b1, 1'b0, 0);
  endtask

  task automatic test_gaps();
    bit pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    step(1'b0, 1'b1, 3);
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 6; j++)
        step(pat[j], 1'b0, 0);
  endtask

  task automatic test_clamp();
    step(1'b0, 1'b1, 0);
    for (int i = 0; i < 5; i++)
      step(1'b1, 1'b0, 0);
    step(1'b0, 1'b1, 2000);
    step(1'b1, 1'b0, 0);
  endtask

  task automatic test_midstream_load();
    step(1'b0, 1'b1, 64);
    for (int i = 0; i < 80; i++)
      step(1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 8);
    for (int i = 0; i < 20; i++)
      step(1'b1, 1'b0, 0);
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 10; i++)
      step(1'b1, 1'b0, 0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || filled !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_outputs: got v=%b d=%h f=%b expected 0 0 0", out_valid, out_data, filled);
    end
    checks++;
    if (cur_delay !== 11'(DEFD)) begin
      failures++;
      $display("FAIL async_reset_delay: got %0d expected %0d", cur_delay, DEFD);
    end
    #10;
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 80; i++)
      step(1'b1, 1'b0, 0);
  endtask

  initial begin
    model_reset();
    k = 0;
    step_no = 0;
    test_reset();
    test_stream();
    test_max_delay();
    test_gaps();
    test_clamp();
    test_midstream_load();
    test_reset_midstream();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
